ethernet_control_unit_multislot: RTL and testbench
==================================================

Name: ethernet_control_unit_multislot

Overview:
- Successor MMIO control unit for the Liteeth-compatible Ethernet controller, generalised to multiple RX/TX slots and 32/64-bit data.
- Owns the RX slot ring (fill order, per-slot length, pending state) and a TX command queue.
- Owns interrupt pending/enable state and drives a single irq.
- Sits between the MMIO adapter and the MAC-side RX/TX buffer RAMs.

Parameters:
- eth_mtu_p, 2048: bytes per slot; power of two, at most 2048.
- data_width_p, 32: MMIO/buffer data width; 32 or 64.
- rx_slots_p, 2: number of RX slots, 1..8.
- tx_slots_p, 2: number of TX slots and TX queue depth, 1..8.
- Derived: slot_w = max(1, clog2(slots)); size_w = clog2(eth_mtu_p+1); paddr_w = clog2(eth_mtu_p); reg_base = 2^clog2((rx_slots_p+tx_slots_p)*eth_mtu_p); addr_w = clog2(reg_base)+1. Defaults give reg_base 0x2000 and addr_w 14.

Ports:
- clk_i  in  1  clock; one clock only, all logic on posedge.
- reset_i  in  1  synchronous, active-high reset.
- addr_i  in  addr_w  MMIO byte address.
- read_en_i / write_en_i  in  1 each  MMIO strobes.
- write_mask_i  in  data_width_p/8  byte mask.
- write_data_i  in  data_width_p  write data.
- read_data_o  out  data_width_p  synchronous read data, valid 1 cycle after read_en_i.
- debug_info_i  in  16  debug word.
- packet_rvalid_o / packet_rslot_o / packet_raddr_o  out  1 / slot_w(rx) / paddr_w  RX buffer read request.
- packet_rdata_i  in  data_width_p  RX buffer data, 1-cycle latency.
- packet_wvalid_o / packet_wslot_o / packet_waddr_o / packet_wdata_o / packet_wmask_o  out  TX buffer write request.
- rx_wslot_o  out  slot_w(rx)  slot the MAC fills next.
- rx_full_o  out  1  all RX slots occupied; the MAC must drop frames.
- rx_done_v_i  in  1  MAC finished a frame into rx_wslot_o.
- rx_done_size_i  in  size_w  length of that frame in bytes.
- tx_v_o / tx_slot_o / tx_size_o  out  1 / slot_w(tx) / size_w  head of the TX queue.
- tx_yumi_i  in  1  MAC dequeues the TX head.
- tx_done_i  in  1  MAC finished transmitting a frame.
- irq_o  out  1  combined interrupt.

Behaviour:
- Address decode:
  - RX buffer slot s: [s*mtu, (s+1)*mtu).
  - TX buffer slot t: [(rx_slots_p+t)*mtu, ...).
  - Registers at reg_base+off, with off in {0x00 RX slot R, 0x04 RX length R, 0x10 RX pending RW1C, 0x14 RX enable W, 0x18 TX start W, 0x1C TX ready R, 0x24 TX slot W, 0x28 TX length W, 0x30 TX pending RW1C, 0x34 TX enable W, 0x50 debug R}.
  - Reads return zero-extended values.
- Read path: one output register stage. Buffer reads return packet_rdata_i; register reads return a value latched on the read_en_i cycle. read_data_o holds between reads.
- RX ring: rd_ptr, wr_ptr, count (0..rx_slots_p), and len[rx_slots_p] registers.
  - rx_done_v_i with count<rx_slots_p: latch len[wr_ptr] from rx_done_size_i, advance wr_ptr mod rx_slots_p, count+1.
  - rx_done_v_i while full: ignored.
  - Writing bit0=1 to RX pending with count>0: advance rd_ptr, count-1. Pop while empty: no effect.
  - Done and pop in the same cycle: both pointers advance, count unchanged. This also applies when full.
  - RX slot reads rd_ptr; RX length reads len[rd_ptr], or 0 if count==0.
  - RX pending reads (count!=0). rx_full_o = (count==rx_slots_p). rx_wslot_o = wr_ptr.
- TX queue: FIFO of {slot, size}, depth tx_slots_p.
  - TX slot and TX length are staging registers, reset to 0. Length is saturated to eth_mtu_p.
  - Write to TX start enqueues {staged slot, staged length} if not full. If full the write is dropped and flagged as a decode error.
  - TX ready reads (not full).
  - tx_v_o = not empty; head is dequeued on tx_yumi_i & tx_v_o. Enqueue and dequeue in the same cycle is allowed when full.
- Interrupts:
  - tx_pending is set by tx_done_i and cleared by writing bit0=1 to TX pending. Set wins over a simultaneous clear.
  - rx_en and tx_en are written from bit0 of their registers.
  - irq_o = (count!=0 & rx_en) | (tx_pending & tx_en), registered.
- Reset values: all pointers, counts, enables, pending bits, staging registers, read_data_o and irq_o are 0; tx_v_o=0; rx_full_o=0.
- Decode errors (simulation assertion only, no hardware effect):
  - unmapped address;
  - write to a read-only location, or read from a write-only location;
  - read_en_i and write_en_i asserted together;
  - TX slot written >= tx_slots_p;
  - enqueue while the TX queue is full.

Optional Feature:
- Macro ETH_CTRL_STATS_EN. When defined, adds three 32-bit saturating counters, all read-only and cleared by reset:
  - rx_frames at off 0x54, counting accepted rx_done_v_i;
  - rx_drops at off 0x58, counting rx_done_v_i while full;
  - tx_frames at off 0x5C, counting tx_done_i.
- When undefined, offsets 0x54–0x5C decode as unmapped and no counter flops exist.

Test Plan:
- Reset, then read reg_base+0x1C and +0x10 -> 1 and 0; irq_o=0; tx_v_o=0.
- rx_done_v_i with size 60, then 1514 -> RX slot 0, length 60; W1C pending -> slot 1, length 1514; W1C -> pending 0.
- Fill 2 RX slots, then a third rx_done_v_i -> rx_full_o=1, third frame ignored, rx_drops=1 with the macro defined. Pop concurrently with a done -> count stays 2.
- TX slot=1, length=3000, start -> tx_v_o=1, tx_slot_o=1, tx_size_o=2048. Enqueue twice more with no yumi -> TX ready reads 0 and an assertion fires on the third start.
- Enable RX and TX interrupts; tx_done_i -> irq_o=1 next cycle. Clear TX pending in the same cycle as another tx_done_i -> pending stays 1.
- Write 0xDEADBEEF with mask 0b0101 to TX slot 0 offset 0x10 -> packet_wvalid_o=1, wslot 0, waddr 0x10, wmask 0b0101 in the same cycle.

Source files
------------

// File: rtl/ethernet_control_unit_multislot.sv
// ethernet_control_unit_multislot
// MMIO control unit for a Liteeth-compatible Ethernet controller with several
// RX/TX slots. It owns the RX slot ring, the TX command queue and the
// interrupt state. It also routes MMIO buffer accesses to the MAC-side RAMs.
//
// Optional feature: define ETH_CTRL_STATS_EN to add three read-only saturating
// frame counters (rx_frames 0x54, rx_drops 0x58, tx_frames 0x5C).
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   addr_i, read_en_i, write_en_i  MMIO request (byte address)
//   write_mask_i, write_data_i     MMIO byte mask and write data
//   read_data_o                    read data, valid one cycle after read_en_i
//   debug_info_i                   debug word returned at offset 0x50
//   packet_r*                      RX buffer read request / 1-cycle data
//   packet_w*                      TX buffer write request
//   rx_wslot_o, rx_full_o          slot the MAC fills next / ring full
//   rx_done_v_i, rx_done_size_i    MAC finished a frame of given length
//   tx_v_o, tx_slot_o, tx_size_o   head of the TX queue
//   tx_yumi_i, tx_done_i           MAC dequeues head / finished a frame
//   irq_o                          combined interrupt
module ethernet_control_unit_multislot #(
   parameter int eth_mtu_p    = 2048,
   parameter int data_width_p = 32,
   parameter int rx_slots_p   = 2,
   parameter int tx_slots_p   = 2,
   localparam int rx_slot_w   = (rx_slots_p > 1) ? $clog2(rx_slots_p) : 1,
   localparam int tx_slot_w   = (tx_slots_p > 1) ? $clog2(tx_slots_p) : 1,
   localparam int size_w      = $clog2(eth_mtu_p + 1),
   localparam int paddr_w     = $clog2(eth_mtu_p),
   localparam int reg_base    = 2 ** $clog2((rx_slots_p + tx_slots_p) * eth_mtu_p),
   localparam int addr_w      = $clog2(reg_base) + 1,
   localparam int mask_w      = data_width_p / 8
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [addr_w-1:0]       addr_i,
   input  logic                    read_en_i,
   input  logic                    write_en_i,
   input  logic [mask_w-1:0]       write_mask_i,
   input  logic [data_width_p-1:0] write_data_i,
   output logic [data_width_p-1:0] read_data_o,
   input  logic [15:0]             debug_info_i,
   output logic                    packet_rvalid_o,
   output logic [rx_slot_w-1:0]    packet_rslot_o,
   output logic [paddr_w-1:0]      packet_raddr_o,
   input  logic [data_width_p-1:0] packet_rdata_i,
   output logic                    packet_wvalid_o,
   output logic [tx_slot_w-1:0]    packet_wslot_o,
   output logic [paddr_w-1:0]      packet_waddr_o,
   output logic [data_width_p-1:0] packet_wdata_o,
   output logic [mask_w-1:0]       packet_wmask_o,
   output logic [rx_slot_w-1:0]    rx_wslot_o,
   output logic                    rx_full_o,
   input  logic                    rx_done_v_i,
   input  logic [size_w-1:0]       rx_done_size_i,
   output logic                    tx_v_o,
   output logic [tx_slot_w-1:0]    tx_slot_o,
   output logic [size_w-1:0]       tx_size_o,
   input  logic                    tx_yumi_i,
   input  logic                    tx_done_i,
   output logic                    irq_o
);

   localparam int ofs_w    = addr_w - 1;
   localparam int bidx_w   = addr_w - 1 - paddr_w;
   localparam int rx_cnt_w = $clog2(rx_slots_p + 1);
   localparam int tx_cnt_w = $clog2(tx_slots_p + 1);
   localparam logic [rx_cnt_w-1:0]     rx_full_cnt = rx_cnt_w'(rx_slots_p);
   localparam logic [tx_cnt_w-1:0]     tx_full_cnt = tx_cnt_w'(tx_slots_p);
   localparam logic [rx_slot_w-1:0]    rx_last     = rx_slot_w'(rx_slots_p - 1);
   localparam logic [tx_slot_w-1:0]    tx_last     = tx_slot_w'(tx_slots_p - 1);
   localparam logic [data_width_p-1:0] mtu_d       = data_width_p'(eth_mtu_p);
   localparam logic [data_width_p-1:0] tx_slots_d  = data_width_p'(tx_slots_p);

   typedef enum logic [3:0] {
      R_NONE, R_RX_SLOT, R_RX_LEN, R_RX_PEND, R_RX_EN, R_TX_START, R_TX_READY,
      R_TX_SLOT, R_TX_LEN, R_TX_PEND, R_TX_EN, R_DEBUG, R_RX_FRAMES, R_RX_DROPS,
      R_TX_FRAMES
   } reg_sel_e;

   function automatic logic [rx_slot_w-1:0] rx_inc(input logic [rx_slot_w-1:0] p);
      return (p == rx_last) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [tx_slot_w-1:0] tx_inc(input logic [tx_slot_w-1:0] p);
      return (p == tx_last) ? '0 : p + 1'b1;
   endfunction

   // Address split: the top bit selects the register window; below it the
   // buffer space is carved into mtu-sized slots, RX slots first, then TX.
   logic              in_regs;
   logic [ofs_w-1:0]  reg_off;
   logic [bidx_w-1:0] buf_idx;
   logic              hit_rx_buf, hit_tx_buf;
   reg_sel_e          reg_sel;
   logic              reg_readable, reg_writable;

   assign in_regs    = addr_i[addr_w-1];
   assign reg_off    = addr_i[addr_w-2:0];
   assign buf_idx    = addr_i[addr_w-2:paddr_w];
   assign hit_rx_buf = !in_regs && (int'(buf_idx) < rx_slots_p);
   assign hit_tx_buf = !in_regs && (int'(buf_idx) >= rx_slots_p)
                       && (int'(buf_idx) < rx_slots_p + tx_slots_p);

   // Register offset decode; the counter offsets only exist with stats enabled.
   always_comb begin
      reg_sel = R_NONE;
      if (in_regs) begin
         case (reg_off)
            ofs_w'(8'h00): reg_sel = R_RX_SLOT;
            ofs_w'(8'h04): reg_sel = R_RX_LEN;
            ofs_w'(8'h10): reg_sel = R_RX_PEND;
            ofs_w'(8'h14): reg_sel = R_RX_EN;
            ofs_w'(8'h18): reg_sel = R_TX_START;
            ofs_w'(8'h1C): reg_sel = R_TX_READY;
            ofs_w'(8'h24): reg_sel = R_TX_SLOT;
            ofs_w'(8'h28): reg_sel = R_TX_LEN;
            ofs_w'(8'h30): reg_sel = R_TX_PEND;
            ofs_w'(8'h34): reg_sel = R_TX_EN;
            ofs_w'(8'h50): reg_sel = R_DEBUG;
`ifdef ETH_CTRL_STATS_EN
            ofs_w'(8'h54): reg_sel = R_RX_FRAMES;
            ofs_w'(8'h58): reg_sel = R_RX_DROPS;
            ofs_w'(8'h5C): reg_sel = R_TX_FRAMES;
`endif
            default:       reg_sel = R_NONE;
         endcase
      end
      reg_writable = reg_sel inside {R_RX_PEND, R_RX_EN, R_TX_START, R_TX_SLOT,
                                     R_TX_LEN, R_TX_PEND, R_TX_EN};
      reg_readable = (reg_sel != R_NONE) &&
                     !(reg_sel inside {R_RX_EN, R_TX_START, R_TX_SLOT, R_TX_LEN, R_TX_EN});
   end

   // Buffer requests go straight through to the RAMs in the access cycle.
   assign packet_rvalid_o = read_en_i && hit_rx_buf;
   assign packet_rslot_o  = rx_slot_w'(buf_idx);
   assign packet_raddr_o  = addr_i[paddr_w-1:0];
   assign packet_wvalid_o = write_en_i && hit_tx_buf;
   assign packet_wslot_o  = tx_slot_w'(buf_idx - bidx_w'(rx_slots_p));
   assign packet_waddr_o  = addr_i[paddr_w-1:0];
   assign packet_wdata_o  = write_data_i;
   assign packet_wmask_o  = write_mask_i;

   // State
   logic [rx_slot_w-1:0] rx_rd_ptr_q, rx_wr_ptr_q, rx_rd_ptr_n, rx_wr_ptr_n;
   logic [rx_cnt_w-1:0]  rx_count_q, rx_count_n;
   logic [size_w-1:0]    rx_len_q [rx_slots_p];
   logic [tx_slot_w-1:0] tx_head_q, tx_tail_q, tx_head_n, tx_tail_n;
   logic [tx_cnt_w-1:0]  tx_count_q, tx_count_n;
   logic [tx_slot_w-1:0] tx_slot_fifo_q [tx_slots_p];
   logic [size_w-1:0]    tx_size_fifo_q [tx_slots_p];
   logic [tx_slot_w-1:0] stage_slot_q, stage_slot_n;
   logic [size_w-1:0]    stage_len_q, stage_len_n;
   logic                 rx_en_q, rx_en_n, tx_en_q, tx_en_n;
   logic                 tx_pend_q, tx_pend_n, irq_q;
   logic [data_width_p-1:0] rd_q, rd_val, wdata_m;
   logic                 buf_sel_q;
   logic                 rx_pop, rx_push, rx_drop, tx_enq, tx_deq, enq_req, decode_err;
`ifdef ETH_CTRL_STATS_EN
   logic [31:0]          rx_frames_q, rx_drops_q, tx_frames_q;
`endif

   // Byte-masked write data so partial writes only touch enabled lanes.
   always_comb begin
      wdata_m = '0;
      for (int b = 0; b < mask_w; b++)
         wdata_m[b*8 +: 8] = write_mask_i[b] ? write_data_i[b*8 +: 8] : 8'h00;
   end

   // Ring and queue handshakes. A pop frees a slot in the same cycle, so a
   // done arriving while full is still accepted when a pop accompanies it.
   assign rx_pop  = write_en_i && (reg_sel == R_RX_PEND) && wdata_m[0] && (rx_count_q != '0);
   assign rx_push = rx_done_v_i && ((rx_count_q != rx_full_cnt) || rx_pop);
   assign rx_drop = rx_done_v_i && !rx_push;
   assign tx_deq  = tx_yumi_i && tx_v_o;
   assign enq_req = write_en_i && (reg_sel == R_TX_START);
   assign tx_enq  = enq_req && ((tx_count_q != tx_full_cnt) || tx_deq);

   // Next-state for pointers, counts, staging and interrupt bits.
   always_comb begin
      rx_rd_ptr_n  = rx_pop  ? rx_inc(rx_rd_ptr_q) : rx_rd_ptr_q;
      rx_wr_ptr_n  = rx_push ? rx_inc(rx_wr_ptr_q) : rx_wr_ptr_q;
      rx_count_n   = rx_count_q;
      if (rx_push && !rx_pop) rx_count_n = rx_count_q + 1'b1;
      if (!rx_push && rx_pop) rx_count_n = rx_count_q - 1'b1;
      tx_head_n    = tx_deq ? tx_inc(tx_head_q) : tx_head_q;
      tx_tail_n    = tx_enq ? tx_inc(tx_tail_q) : tx_tail_q;
      tx_count_n   = tx_count_q;
      if (tx_enq && !tx_deq) tx_count_n = tx_count_q + 1'b1;
      if (!tx_enq && tx_deq) tx_count_n = tx_count_q - 1'b1;
      stage_slot_n = stage_slot_q;
      stage_len_n  = stage_len_q;
      rx_en_n      = rx_en_q;
      tx_en_n      = tx_en_q;
      tx_pend_n    = tx_pend_q;
      if (write_en_i) begin
         case (reg_sel)
            R_TX_SLOT: stage_slot_n = tx_slot_w'(wdata_m);
            R_TX_LEN:  stage_len_n  = (wdata_m > mtu_d) ? size_w'(eth_mtu_p) : size_w'(wdata_m);
            R_RX_EN:   rx_en_n      = wdata_m[0];
            R_TX_EN:   tx_en_n      = wdata_m[0];
            R_TX_PEND: if (wdata_m[0]) tx_pend_n = 1'b0;
            default:   ;
         endcase
      end
      if (tx_done_i) tx_pend_n = 1'b1;
   end

   // Register read mux, sampled into the output stage on read_en_i.
   always_comb begin
      rd_val = '0;
      case (reg_sel)
         R_RX_SLOT:   rd_val = data_width_p'(rx_rd_ptr_q);
         R_RX_LEN:    rd_val = (rx_count_q != '0) ? data_width_p'(rx_len_q[rx_rd_ptr_q]) : '0;
         R_RX_PEND:   rd_val = data_width_p'(rx_count_q != '0);
         R_TX_READY:  rd_val = data_width_p'(tx_count_q != tx_full_cnt);
         R_TX_PEND:   rd_val = data_width_p'(tx_pend_q);
         R_DEBUG:     rd_val = data_width_p'(debug_info_i);
`ifdef ETH_CTRL_STATS_EN
         R_RX_FRAMES: rd_val = data_width_p'(rx_frames_q);
         R_RX_DROPS:  rd_val = data_width_p'(rx_drops_q);
         R_TX_FRAMES: rd_val = data_width_p'(tx_frames_q);
`endif
         default:     rd_val = '0;
      endcase
   end

   // Main state registers. irq is computed from next-state values so it
   // reacts in the cycle right after the causing event.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rx_rd_ptr_q  <= '0;
         rx_wr_ptr_q  <= '0;
         rx_count_q   <= '0;
         tx_head_q    <= '0;
         tx_tail_q    <= '0;
         tx_count_q   <= '0;
         stage_slot_q <= '0;
         stage_len_q  <= '0;
         rx_en_q      <= 1'b0;
         tx_en_q      <= 1'b0;
         tx_pend_q    <= 1'b0;
         irq_q        <= 1'b0;
         for (int i = 0; i < rx_slots_p; i++) rx_len_q[i] <= '0;
         for (int i = 0; i < tx_slots_p; i++) begin
            tx_slot_fifo_q[i] <= '0;
            tx_size_fifo_q[i] <= '0;
         end
      end else begin
         rx_rd_ptr_q  <= rx_rd_ptr_n;
         rx_wr_ptr_q  <= rx_wr_ptr_n;
         rx_count_q   <= rx_count_n;
         tx_head_q    <= tx_head_n;
         tx_tail_q    <= tx_tail_n;
         tx_count_q   <= tx_count_n;
         stage_slot_q <= stage_slot_n;
         stage_len_q  <= stage_len_n;
         rx_en_q      <= rx_en_n;
         tx_en_q      <= tx_en_n;
         tx_pend_q    <= tx_pend_n;
         irq_q        <= ((rx_count_n != '0) && rx_en_n) || (tx_pend_n && tx_en_n);
         if (rx_push) rx_len_q[rx_wr_ptr_q] <= rx_done_size_i;
         if (tx_enq) begin
            tx_slot_fifo_q[tx_tail_q] <= stage_slot_q;
            tx_size_fifo_q[tx_tail_q] <= stage_len_q;
         end
      end
   end

   // Output stage. Buffer data arrives a cycle after the request, so it is
   // passed through while buf_sel_q is set and captured afterwards to hold.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_q      <= '0;
         buf_sel_q <= 1'b0;
      end else begin
         buf_sel_q <= read_en_i && hit_rx_buf;
         if (read_en_i && !hit_rx_buf) rd_q <= rd_val;
         else if (buf_sel_q)           rd_q <= packet_rdata_i;
      end
   end

`ifdef ETH_CTRL_STATS_EN
   // Saturating frame counters.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rx_frames_q <= '0;
         rx_drops_q  <= '0;
         tx_frames_q <= '0;
      end else begin
         if (rx_push && (rx_frames_q != '1))   rx_frames_q <= rx_frames_q + 1'b1;
         if (rx_drop && (rx_drops_q != '1))    rx_drops_q  <= rx_drops_q + 1'b1;
         if (tx_done_i && (tx_frames_q != '1)) tx_frames_q <= tx_frames_q + 1'b1;
      end
   end
`endif

   assign read_data_o = buf_sel_q ? packet_rdata_i : rd_q;
   assign rx_wslot_o  = rx_wr_ptr_q;
   assign rx_full_o   = (rx_count_q == rx_full_cnt);
   assign tx_v_o      = (tx_count_q != '0);
   assign tx_slot_o   = tx_slot_fifo_q[tx_head_q];
   assign tx_size_o   = tx_size_fifo_q[tx_head_q];
   assign irq_o       = irq_q;

   // Software misuse detection; it has no effect on the hardware state.
   always_comb begin
      decode_err = 1'b0;
      if ((read_en_i || write_en_i) && !hit_rx_buf && !hit_tx_buf && (reg_sel == R_NONE))
         decode_err = 1'b1;
      if (write_en_i && (hit_rx_buf || ((reg_sel != R_NONE) && !reg_writable)))
         decode_err = 1'b1;
      if (read_en_i && (hit_tx_buf || ((reg_sel != R_NONE) && !reg_readable)))
         decode_err = 1'b1;
      if (read_en_i && write_en_i)
         decode_err = 1'b1;
      if (write_en_i && (reg_sel == R_TX_SLOT) && (wdata_m >= tx_slots_d))
         decode_err = 1'b1;
      if (enq_req && !tx_enq)
         decode_err = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!decode_err)
            else $error("ethernet_control_unit_multislot: decode error at address %h", addr_i);
      end
   end

endmodule

// File: tb/tb_ethernet_control_unit_multislot.sv
// Directed testbench for ethernet_control_unit_multislot (default parameters).
module tb_ethernet_control_unit_multislot;

   localparam logic [13:0] REG = 14'h2000;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [13:0] addr_i;
   logic        read_en_i, write_en_i;
   logic [3:0]  write_mask_i;
   logic [31:0] write_data_i, read_data_o;
   logic [15:0] debug_info_i;
   logic        packet_rvalid_o;
   logic [0:0]  packet_rslot_o;
   logic [10:0] packet_raddr_o;
   logic [31:0] packet_rdata_i;
   logic        packet_wvalid_o;
   logic [0:0]  packet_wslot_o;
   logic [10:0] packet_waddr_o;
   logic [31:0] packet_wdata_o;
   logic [3:0]  packet_wmask_o;
   logic [0:0]  rx_wslot_o;
   logic        rx_full_o, rx_done_v_i;
   logic [11:0] rx_done_size_i;
   logic        tx_v_o;
   logic [0:0]  tx_slot_o;
   logic [11:0] tx_size_o;
   logic        tx_yumi_i, tx_done_i, irq_o;

   int total = 0;
   int bad   = 0;
   logic [31:0] rd;

   ethernet_control_unit_multislot dut (
      .clk_i(clk), .reset_i(reset_i), .addr_i(addr_i), .read_en_i(read_en_i),
      .write_en_i(write_en_i), .write_mask_i(write_mask_i), .write_data_i(write_data_i),
      .read_data_o(read_data_o), .debug_info_i(debug_info_i),
      .packet_rvalid_o(packet_rvalid_o), .packet_rslot_o(packet_rslot_o),
      .packet_raddr_o(packet_raddr_o), .packet_rdata_i(packet_rdata_i),
      .packet_wvalid_o(packet_wvalid_o), .packet_wslot_o(packet_wslot_o),
      .packet_waddr_o(packet_waddr_o), .packet_wdata_o(packet_wdata_o),
      .packet_wmask_o(packet_wmask_o), .rx_wslot_o(rx_wslot_o), .rx_full_o(rx_full_o),
      .rx_done_v_i(rx_done_v_i), .rx_done_size_i(rx_done_size_i), .tx_v_o(tx_v_o),
      .tx_slot_o(tx_slot_o), .tx_size_o(tx_size_o), .tx_yumi_i(tx_yumi_i),
      .tx_done_i(tx_done_i), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   // RX buffer RAM model: one-cycle latency, data encodes the requested slot/address.
   always @(posedge clk) packet_rdata_i <= {16'hC0DE, 4'h0, packet_rslot_o, packet_raddr_o};

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic mmio_write(input logic [13:0] a, input logic [31:0] d);
      @(negedge clk);
      addr_i = a; write_data_i = d; write_mask_i = 4'hF; write_en_i = 1'b1;
      @(negedge clk);
      write_en_i = 1'b0;
   endtask

   task automatic mmio_read(input logic [13:0] a, output logic [31:0] d);
      @(negedge clk);
      addr_i = a; read_en_i = 1'b1;
      @(negedge clk);
      read_en_i = 1'b0;
      d = read_data_o;
   endtask

   task automatic rx_done(input logic [11:0] sz);
      @(negedge clk);
      rx_done_v_i = 1'b1; rx_done_size_i = sz;
      @(negedge clk);
      rx_done_v_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; addr_i = '0; read_en_i = 0; write_en_i = 0; write_mask_i = 0;
      write_data_i = 0; debug_info_i = 16'hA5C3; rx_done_v_i = 0; rx_done_size_i = 0;
      tx_yumi_i = 0; tx_done_i = 0;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);
      total++; if (irq_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq: got %0b want 0", irq_o); end
      total++; if (tx_v_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_v: got %0b want 0", tx_v_o); end
      total++; if (rx_full_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_full: got %0b want 0", rx_full_o); end
      total++; if (read_data_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", read_data_o); end
      total++; if (rx_wslot_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_wslot: got %0d want 0", rx_wslot_o); end
      mmio_read(REG + 14'h1C, rd);
      total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL reset_tx_ready: got %h want 1", rd); end
      mmio_read(REG + 14'h10, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_rx_pend: got %h want 0", rd); end
      mmio_read(REG + 14'h50, rd);
      total++; if (rd !== 32'h0000A5C3) begin bad++; $display("[TB] FAIL debug_read: got %h want 0000a5c3", rd); end
   endtask

   task automatic test_rx_ring();
      rx_done(12'd60);
      total++; if (rx_wslot_o !== 1'b1) begin bad++; $display("[TB] FAIL rx_wslot_after1: got %0d want 1", rx_wslot_o); end
      rx_done(12'd1514);
      total++; if (rx_wslot_o !== 1'b0) begin bad++; $display("[TB] FAIL rx_wslot_wrap: got %0d want 0", rx_wslot_o); end
      mmio_read(REG + 14'h00, rd);
      total++; if (rd !== 32'd0) begin bad++; $display("[TB] FAIL rx_slot_a: got %h want 0", rd); end
      mmio_read(REG + 14'h04, rd);
      total++; if (rd !== 32'd60) begin bad++; $display("[TB] FAIL rx_len_a: got %0d want 60", rd); end
      mmio_read(REG + 14'h10, rd);
      total++; if (rd !== 32'd1) begin bad++; $display("[TB] FAIL rx_pend_a: got %h want 1", rd); end
      mmio_write(REG + 14'h10, 32'h1);
      mmio_read(REG + 14'h00, rd);
      total++; if (rd !== 32'd1) begin bad++; $display("[TB] FAIL rx_slot_b: got %h want 1", rd); end
      mmio_read(REG + 14'h04, rd);
      total++; if (rd !== 32'd1514) begin bad++; $display("[TB] FAIL rx_len_b: got %0d want 1514", rd); end
      mmio_write(REG + 14'h10, 32'h1);
      mmio_read(REG + 14'h10, rd);
      total++; if (rd !== 32'd0) begin bad++; $display("[TB] FAIL rx_pend_empty: got %h want 0", rd); end
      mmio_read(REG + 14'h04, rd);
      total++; if (rd !== 32'd0) begin bad++; $display("[TB] FAIL rx_len_empty: got %0d want 0", rd); end
      // Pop while empty must not disturb the pointers.
      mmio_write(REG + 14'h10, 32'h1);
      mmio_read(REG + 14'h00, rd);
      total++; if (rd !== 32'd0) begin bad++; $display("[TB] FAIL rx_pop_empty: got %h want 0", rd); end
   endtask

   task automatic test_rx_buffer_read();
      @(negedge clk);
      addr_i = 14'h0810; read_en_i = 1'b1;
      #1;
      total++; if ({packet_rvalid_o, packet_rslot_o, packet_raddr_o} !== {1'b1, 1'b1, 11'h010}) begin
         bad++; $display("[TB] FAIL rbuf_req: got v=%0b s=%0d a=%h want v=1 s=1 a=010", packet_rvalid_o, packet_rslot_o, packet_raddr_o);
      end
      @(negedge clk);
      read_en_i = 1'b0;
      total++; if (read_data_o !== 32'hC0DE0810) begin bad++; $display("[TB] FAIL rbuf_data: got %h want c0de0810", read_data_o); end
      addr_i = 14'h0004;
      repeat (2) @(negedge clk);
      total++; if (read_data_o !== 32'hC0DE0810) begin bad++; $display("[TB] FAIL rbuf_hold: got %h want c0de0810", read_data_o); end
   endtask

   task automatic test_rx_full();
      rx_done(12'd100);
      rx_done(12'd200);
      total++; if (rx_full_o !== 1'b1) begin bad++; $display("[TB] FAIL rx_full_set: got %0b want 1", rx_full_o); end
      rx_done(12'd300);
      total++; if (rx_wslot_o !== 1'b0) begin bad++; $display("[TB] FAIL rx_drop_wslot: got %0d want 0", rx_wslot_o); end
      mmio_read(REG + 14'h04, rd);
      total++; if (rd !== 32'd100) begin bad++; $display("[TB] FAIL rx_drop_len: got %0d want 100", rd); end
`ifdef ETH_CTRL_STATS_EN
      mmio_read(REG + 14'h58, rd);
      total++; if (rd !== 32'd1) begin bad++; $display("[TB] FAIL stat_rx_drops: got %0d want 1", rd); end
`endif
      // Pop together with a done while full: both pointers move, count stays 2.
      @(negedge clk);
      addr_i = REG + 14'h10; write_data_i = 32'h1; write_mask_i = 4'hF; write_en_i = 1'b1;
      rx_done_v_i = 1'b1; rx_done_size_i = 12'd400;
      @(negedge clk);
      write_en_i = 1'b0; rx_done_v_i = 1'b0;
      total++; if (rx_full_o !== 1'b1) begin bad++; $display("[TB] FAIL rx_concurrent_full: got %0b want 1", rx_full_o); end
      mmio_read(REG + 14'h00, rd);
      total++; if (rd !== 32'd1) begin bad++; $display("[TB] FAIL rx_concurrent_slot: got %h want 1", rd); end
      mmio_read(REG + 14'h04, rd);
      total++; if (rd !== 32'd200) begin bad++; $display("[TB] FAIL rx_concurrent_len1: got %0d want 200", rd); end
      mmio_write(REG + 14'h10, 32'h1);
      mmio_read(REG + 14'h04, rd);
      total++; if (rd !== 32'd400) begin bad++; $display("[TB] FAIL rx_concurrent_len0: got %0d want 400", rd); end
      mmio_write(REG + 14'h10, 32'h1);
      total++; if (rx_full_o !== 1'b0) begin bad++; $display("[TB] FAIL rx_drained: got %0b want 0", rx_full_o); end
`ifdef ETH_CTRL_STATS_EN
      mmio_read(REG + 14'h54, rd);
      total++; if (rd !== 32'd5) begin bad++; $display("[TB] FAIL stat_rx_frames: got %0d want 5", rd); end
`endif
   endtask

   task automatic test_tx_queue();
      mmio_write(REG + 14'h24, 32'd1);
      mmio_write(REG + 14'h28, 32'd3000);
      mmio_write(REG + 14'h18, 32'd1);
      total++; if ({tx_v_o, tx_slot_o, tx_size_o} !== {1'b1, 1'b1, 12'd2048}) begin
         bad++; $display("[TB] FAIL tx_head_sat: got v=%0b s=%0d z=%0d want v=1 s=1 z=2048", tx_v_o, tx_slot_o, tx_size_o);
      end
      mmio_read(REG + 14'h1C, rd);
      total++; if (rd !== 32'd1) begin bad++; $display("[TB] FAIL tx_ready_one: got %h want 1", rd); end
      mmio_write(REG + 14'h24, 32'd0);
      mmio_write(REG + 14'h28, 32'd64);
      mmio_write(REG + 14'h18, 32'd1);
      mmio_read(REG + 14'h1C, rd);
      total++; if (rd !== 32'd0) begin bad++; $display("[TB] FAIL tx_ready_full: got %h want 0", rd); end
      total++; if ({tx_slot_o, tx_size_o} !== {1'b1, 12'd2048}) begin
         bad++; $display("[TB] FAIL tx_head_full: got s=%0d z=%0d want s=1 z=2048", tx_slot_o, tx_size_o);
      end
      @(negedge clk); tx_yumi_i = 1'b1; @(negedge clk); tx_yumi_i = 1'b0;
      total++; if ({tx_v_o, tx_slot_o, tx_size_o} !== {1'b1, 1'b0, 12'd64}) begin
         bad++; $display("[TB] FAIL tx_head_pop: got v=%0b s=%0d z=%0d want v=1 s=0 z=64", tx_v_o, tx_slot_o, tx_size_o);
      end
      mmio_write(REG + 14'h18, 32'd1);
      mmio_write(REG + 14'h24, 32'd1);
      mmio_write(REG + 14'h28, 32'd100);
      // Enqueue while full but dequeuing in the same cycle.
      @(negedge clk);
      addr_i = REG + 14'h18; write_data_i = 32'h1; write_en_i = 1'b1; tx_yumi_i = 1'b1;
      @(negedge clk);
      write_en_i = 1'b0; tx_yumi_i = 1'b0;
      mmio_read(REG + 14'h1C, rd);
      total++; if (rd !== 32'd0) begin bad++; $display("[TB] FAIL tx_enq_deq_full: got %h want 0", rd); end
      @(negedge clk); tx_yumi_i = 1'b1; @(negedge clk); tx_yumi_i = 1'b0;
      total++; if ({tx_v_o, tx_slot_o, tx_size_o} !== {1'b1, 1'b1, 12'd100}) begin
         bad++; $display("[TB] FAIL tx_head_last: got v=%0b s=%0d z=%0d want v=1 s=1 z=100", tx_v_o, tx_slot_o, tx_size_o);
      end
      @(negedge clk); tx_yumi_i = 1'b1; @(negedge clk); tx_yumi_i = 1'b0;
      total++; if (tx_v_o !== 1'b0) begin bad++; $display("[TB] FAIL tx_empty: got %0b want 0", tx_v_o); end
   endtask

   task automatic test_interrupts();
      mmio_write(REG + 14'h14, 32'h1);
      mmio_write(REG + 14'h34, 32'h1);
      total++; if (irq_o !== 1'b0) begin bad++; $display("[TB] FAIL irq_idle: got %0b want 0", irq_o); end
      @(negedge clk); tx_done_i = 1'b1; @(negedge clk); tx_done_i = 1'b0;
      total++; if (irq_o !== 1'b1) begin bad++; $display("[TB] FAIL irq_tx_done: got %0b want 1", irq_o); end
      @(negedge clk);
      addr_i = REG + 14'h30; write_data_i = 32'h1; write_en_i = 1'b1; tx_done_i = 1'b1;
      @(negedge clk);
      write_en_i = 1'b0; tx_done_i = 1'b0;
      mmio_read(REG + 14'h30, rd);
      total++; if (rd !== 32'd1) begin bad++; $display("[TB] FAIL tx_pend_set_wins: got %h want 1", rd); end
      mmio_write(REG + 14'h30, 32'h1);
      mmio_read(REG + 14'h30, rd);
      total++; if (rd !== 32'd0) begin bad++; $display("[TB] FAIL tx_pend_clear: got %h want 0", rd); end
      total++; if (irq_o !== 1'b0) begin bad++; $display("[TB] FAIL irq_cleared: got %0b want 0", irq_o); end
      rx_done(12'd64);
      total++; if (irq_o !== 1'b1) begin bad++; $display("[TB] FAIL irq_rx: got %0b want 1", irq_o); end
      mmio_write(REG + 14'h14, 32'h0);
      total++; if (irq_o !== 1'b0) begin bad++; $display("[TB] FAIL irq_rx_disabled: got %0b want 0", irq_o); end
      mmio_write(REG + 14'h10, 32'h1);
`ifdef ETH_CTRL_STATS_EN
      mmio_read(REG + 14'h5C, rd);
      total++; if (rd !== 32'd2) begin bad++; $display("[TB] FAIL stat_tx_frames: got %0d want 2", rd); end
`endif
   endtask

   task automatic test_tx_buffer_write();
      @(negedge clk);
      addr_i = 14'h1010; write_data_i = 32'hDEADBEEF; write_mask_i = 4'b0101; write_en_i = 1'b1;
      #1;
      total++; if ({packet_wvalid_o, packet_wslot_o, packet_waddr_o, packet_wmask_o, packet_wdata_o} !==
                   {1'b1, 1'b0, 11'h010, 4'b0101, 32'hDEADBEEF}) begin
         bad++; $display("[TB] FAIL wbuf_slot0: got v=%0b s=%0d a=%h m=%b d=%h want v=1 s=0 a=010 m=0101 d=deadbeef",
                         packet_wvalid_o, packet_wslot_o, packet_waddr_o, packet_wmask_o, packet_wdata_o);
      end
      total++; if (packet_rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL wbuf_no_rvalid: got %0b want 0", packet_rvalid_o); end
      @(negedge clk);
      addr_i = 14'h1FFC; write_data_i = 32'h12345678; write_mask_i = 4'hF;
      #1;
      total++; if ({packet_wvalid_o, packet_wslot_o, packet_waddr_o} !== {1'b1, 1'b1, 11'h7FC}) begin
         bad++; $display("[TB] FAIL wbuf_slot1_top: got v=%0b s=%0d a=%h want v=1 s=1 a=7fc", packet_wvalid_o, packet_wslot_o, packet_waddr_o);
      end
      @(negedge clk);
      write_en_i = 1'b0;
      #1;
      total++; if (packet_wvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL wbuf_idle: got %0b want 0", packet_wvalid_o); end
   endtask

   initial begin
      test_reset();
      test_rx_ring();
      test_rx_buffer_read();
      test_rx_full();
      test_tx_queue();
      test_interrupts();
      test_tx_buffer_write();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
